reg_bank_fwd: RTL
=================

// Module: reg_bank_fwd
// PURPOSE
//  Parametrised pipeline register file for the MIPS datapath; successor to the fixed 32x16 bank.
//  Two registered read ports and one write port, gated by a write enable.
//  Per-port 4-way forwarding mux (reg/ex/dm/wb) and an immediate override on port B.
//  Adds a write-pending scoreboard, so decode can detect RAW hazards not covered by forwarding.
// PARAMETERS
//  DW       16  data width of registers, forwarding inputs and imm
//  DEPTH    32  number of registers; power of 2, 2..256
//  AW       5   address width, localparam = $clog2(DEPTH)
//  R0_ZERO  1   1: register 0 reads 0, writes to it ignored, never marked busy; 0: ordinary register
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  ra         in   AW     read address, port A
//  rb         in   AW     read address, port B
//  we         in   1      write enable
//  rw         in   AW     write address
//  wd         in   DW     write data
//  ans_ex     in   DW     forwarded EX result
//  ans_dm     in   DW     forwarded DM result
//  ans_wb     in   DW     forwarded WB result
//  imm        in   DW     immediate operand
//  mux_sel_a  in   2      A source: 00 reg, 01 ex, 10 dm, 11 wb
//  mux_sel_b  in   2      B source: same encoding as mux_sel_a
//  imm_sel    in   1      1: b = imm, overriding mux_sel_b
//  iss_vld    in   1      instruction issued that will write iss_rd
//  iss_rd     in   AW     destination of the issued instruction
//  a          out  DW     operand A
//  b          out  DW     operand B
//  busy_a     out  1      busy[ra], combinational
//  busy_b     out  1      busy[rb], combinational
//  busy_vec   out  DEPTH  full scoreboard, bit i = register i pending
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers, reg_a/reg_b read latches and busy_vec clear to 0.
//   Outputs during reset: a = 0 and b = 0 when sel = 00 and imm_sel = 0; busy_a = busy_b = 0.
//  Read: reg_a <= mem[ra] and reg_b <= mem[rb] on posedge clk. Latency 1 cycle, address to reg_a/reg_b.
//  Write: if we, mem[rw] <= wd on posedge clk. No write when we = 0.
//  Read/write to same address in the same cycle: see CONFIGURATION.
//  Output mux is combinational:
//   a = {reg_a, ans_ex, ans_dm, ans_wb}[mux_sel_a]
//   b = imm_sel ? imm : {reg_b, ans_ex, ans_dm, ans_wb}[mux_sel_b]
//  R0_ZERO=1: a read of addr 0 latches 0; writes to addr 0 are dropped; iss_rd = 0 does not set busy.
//  Scoreboard, per clock edge:
//   iss_vld sets busy[iss_rd].
//   we clears busy[rw].
//   Set and clear on the same register in one cycle: set wins (new producer issued).
//   Set and clear on different registers: both take effect.
//   Issue to an already-busy register keeps it busy. Clear of a non-busy register is a no-op.
//  No width arithmetic; all data paths are DW bits, no truncation or extension.
//  Reset asserted mid-operation: any in-flight write is lost and all busy bits drop at once.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   we && rw == ra (and rw != 0 when R0_ZERO) -> reg_a latches wd, not the old mem value.
//   Same rule for port B. Write-then-read of one address costs no extra cycle.
//  REGFILE_BYPASS_EN undefined:
//   reg_a/reg_b latch the pre-write value (read-before-write).
//   The hazard unit must forward via mux_sel = 11.
// TESTING
//  1. rst_n=0 mid-run, all selects 0 -> a = b = 0 and busy_vec = 0 immediately, without waiting for clk.
//  2. we=1, rw=5, wd=16'hBEEF; next cycle ra=5 -> a = 16'hBEEF one cycle later.
//  3. Same-cycle we=1, rw=7, wd=16'h1234, ra=7 (mem[7]=16'h0011):
//     -> a = 16'h1234 with REGFILE_BYPASS_EN, 16'h0011 without.
//  4. R0_ZERO=1: we=1, rw=0, wd=16'hFFFF, then ra=0 -> a = 0; iss_vld=1, iss_rd=0 -> busy_vec[0] = 0.
//  5. Forwarding inputs ex=1, dm=2, wb=3, imm=9:
//     sweep mux_sel_a 00..11 -> a = reg_a, 1, 2, 3; imm_sel=1 -> b = 9 whatever mux_sel_b is.
//  6. Scoreboard: iss_vld, iss_rd=3 -> busy_vec[3] = 1, busy_a = 1 for ra=3.
//     Then iss_vld, iss_rd=3 together with we, rw=3 -> stays 1.
//     Then we, rw=3 alone -> busy_vec[3] = 0.

Source files
------------

// File: rtl/reg_bank_fwd.sv
// Parametrised pipeline register file: two registered read ports, one write port,
// 4-way operand forwarding, imm override on B, and a write-pending scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module reg_bank_fwd #(
    parameter int unsigned DW      = 16,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned R0_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DEPTH)-1:0] ra,
    input  logic [$clog2(DEPTH)-1:0] rb,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] rw,
    input  logic [DW-1:0]            wd,
    input  logic [DW-1:0]            ans_ex,
    input  logic [DW-1:0]            ans_dm,
    input  logic [DW-1:0]            ans_wb,
    input  logic [DW-1:0]            imm,
    input  logic [1:0]               mux_sel_a,
    input  logic [1:0]               mux_sel_b,
    input  logic                     imm_sel,
    input  logic                     iss_vld,
    input  logic [$clog2(DEPTH)-1:0] iss_rd,
    output logic [DW-1:0]            a,
    output logic [DW-1:0]            b,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam bit          R0 = (R0_ZERO != 0);
`ifdef REGFILE_BYPASS_EN
    localparam bit          BYP = 1'b1;
`else
    localparam bit          BYP = 1'b0;
`endif

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DW-1:0]    r_reg_a;
    logic [DW-1:0]    r_reg_b;
    logic [DEPTH-1:0] r_busy;

    logic             w_wr_en;
    logic             w_iss_en;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_byp_a;
    logic             w_byp_b;
    logic [DEPTH-1:0] w_busy_nxt;

    // Register 0 is hardwired when R0 is set: no writes, no busy, reads as zero.
    assign w_wr_en  = we && !(R0 && (rw == AW'(0)));
    assign w_iss_en = iss_vld && !(R0 && (iss_rd == AW'(0)));
    assign w_a_zero = R0 && (ra == AW'(0));
    assign w_b_zero = R0 && (rb == AW'(0));
    assign w_byp_a  = BYP && w_wr_en && (rw == ra);
    assign w_byp_b  = BYP && w_wr_en && (rw == rb);

    // Scoreboard next state: clear first so a same-register issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we) begin
            w_busy_nxt[rw] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_reg_a <= '0;
            r_reg_b <= '0;
            r_busy  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[rw] <= wd;
            end
            r_reg_a <= w_a_zero ? '0 : (w_byp_a ? wd : r_mem[ra]);
            r_reg_b <= w_b_zero ? '0 : (w_byp_b ? wd : r_mem[rb]);
            r_busy  <= w_busy_nxt;
        end
    end

    // Operand selection: register, EX, DM or WB result; imm overrides B.
    always_comb begin
        a = r_reg_a;
        case (mux_sel_a)
            2'b00:   a = r_reg_a;
            2'b01:   a = ans_ex;
            2'b10:   a = ans_dm;
            default: a = ans_wb;
        endcase
        b = r_reg_b;
        if (imm_sel) begin
            b = imm;
        end else begin
            case (mux_sel_b)
                2'b00:   b = r_reg_b;
                2'b01:   b = ans_ex;
                2'b10:   b = ans_dm;
                default: b = ans_wb;
            endcase
        end
    end

    assign busy_a   = r_busy[ra];
    assign busy_b   = r_busy[rb];
    assign busy_vec = r_busy;

endmodule
